// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } dmem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } dmem_size_e;

    localparam logic [3:0] WSTRB_BYTE = 4'b0001;
    localparam logic [3:0] WSTRB_HALF = 4'b0011;
    localparam logic [3:0] WSTRB_WORD = 4'hF;

    // Byte wins over half when both decoder flags are set.
    function automatic dmem_size_e decode_size(input logic low_byte, input logic half_word);
        if (low_byte) begin
            return SZ_BYTE;
        end else if (half_word) begin
            return SZ_HALF;
        end
        return SZ_WORD;
    endfunction

    function automatic logic is_misaligned(input dmem_size_e size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/response bus between the access controller and the data-memory wrapper.
interface dmem_access_ctrl_if;

    logic        dm_req_valid;
    logic        dm_req_ready;
    logic        dm_req_write;
    logic [31:0] dm_req_addr;
    logic [3:0]  dm_req_wstrb;
    logic [31:0] dm_req_wdata;
    logic        dm_resp_valid;
    logic [31:0] dm_resp_rdata;

    modport master (
        output dm_req_valid,
        output dm_req_write,
        output dm_req_addr,
        output dm_req_wstrb,
        output dm_req_wdata,
        input  dm_req_ready,
        input  dm_resp_valid,
        input  dm_resp_rdata
    );

    modport slave (
        input  dm_req_valid,
        input  dm_req_write,
        input  dm_req_addr,
        input  dm_req_wstrb,
        input  dm_req_wdata,
        output dm_req_ready,
        output dm_resp_valid,
        output dm_resp_rdata
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store strobes/replication and load extraction/extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  dmem_size_e  size,
    input  logic [1:0]  addr_lo,
    input  logic        padding_zero,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wstrb = WSTRB_WORD;
        wdata = store_data;
        case (size)
            SZ_BYTE: begin
                wstrb = WSTRB_BYTE << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                wstrb = WSTRB_HALF << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                wstrb = WSTRB_WORD;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_ext = rdata;
        case (size)
            SZ_BYTE: load_ext = {{24{~padding_zero & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_ext = {{16{~padding_zero & half_sel[15]}}, half_sel};
            default: load_ext = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences MEM-stage loads/stores onto the data-memory bus and stalls the pipeline meanwhile.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned accesses skip the bus and pulse misalign_err.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_mem,
    input  logic        write_mem,
    input  logic        memin_low_byte,
    input  logic        memin_half_word,
    input  logic        memout_low_byte,
    input  logic        memout_half_word,
    input  logic        padding_zero,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_err,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    dmem_access_ctrl_if.master dm
);

    dmem_state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        bus_err_q, bus_err_d;

    logic [31:0] addr_q;
    dmem_size_e  size_q;
    logic        zext_q;
    logic [31:0] sdata_q;
    logic        write_q;

    logic        req_in;
    dmem_size_e  size_in;
    logic        capture;
    logic        timeout_hit;

    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic        mis_err_q, mis_err_d;
`endif

    assign req_in  = read_mem | write_mem;
    // Read wins when both requests are raised, so size comes from the load flags then.
    assign size_in = read_mem ? decode_size(memout_low_byte, memout_half_word)
                              : decode_size(memin_low_byte, memin_half_word);

    assign timeout_hit = (RESP_TIMEOUT != 0) && (cnt_q == RESP_TIMEOUT - 32'd1);

    dmem_lane_align u_lane_align (
        .size         (size_q),
        .addr_lo      (addr_q[1:0]),
        .padding_zero (zext_q),
        .store_data   (sdata_q),
        .rdata        (dm.dm_resp_rdata),
        .wstrb        (lane_wstrb),
        .wdata        (lane_wdata),
        .load_ext     (lane_load)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        capture      = 1'b0;
        stall        = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_in) begin
                    stall   = 1'b1;
                    capture = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
                    if (is_misaligned(size_in, addr[1:0])) begin
                        state_d     = DONE;
                        load_data_d = '0;
                        mis_err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
`else
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dm.dm_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                stall = 1'b1;
                cnt_d = cnt_q + 32'd1;
                if (dm.dm_resp_valid) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!write_q) begin
                        load_data_d  = lane_load;
                        load_valid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    // Aborted reads report through bus_err only; load_valid stays low.
                    state_d     = DONE;
                    cnt_d       = '0;
                    load_data_d = '0;
                    bus_err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            addr_q       <= '0;
            size_q       <= SZ_BYTE;
            zext_q       <= 1'b0;
            sdata_q      <= '0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_err_q    <= bus_err_d;
            if (capture) begin
                addr_q  <= addr;
                size_q  <= size_in;
                zext_q  <= padding_zero;
                sdata_q <= store_data;
                write_q <= write_mem & ~read_mem;
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_err_q <= 1'b0;
        end else begin
            mis_err_q <= mis_err_d;
        end
    end

    assign misalign_err = mis_err_q;
`endif

    assign load_data       = load_data_q;
    assign load_valid      = load_valid_q;
    assign bus_err         = bus_err_q;

    assign dm.dm_req_valid = (state_q == REQ);
    assign dm.dm_req_write = write_q;
    assign dm.dm_req_addr  = {addr_q[31:2], 2'b00};
    assign dm.dm_req_wstrb = write_q ? lane_wstrb : 4'h0;
    assign dm.dm_req_wdata = lane_wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomised bench for dmem_access_ctrl: per-cycle expectations from a timeline/lane model.
module tb_dmem_access_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read_mem = 1'b0;
    logic        write_mem = 1'b0;
    logic        memin_low_byte = 1'b0;
    logic        memin_half_word = 1'b0;
    logic        memout_low_byte = 1'b0;
    logic        memout_half_word = 1'b0;
    logic        padding_zero = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_err;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    dmem_access_ctrl_if dm_bus ();

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .RESP_TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .read_mem         (read_mem),
        .write_mem        (write_mem),
        .memin_low_byte   (memin_low_byte),
        .memin_half_word  (memin_half_word),
        .memout_low_byte  (memout_low_byte),
        .memout_half_word (memout_half_word),
        .padding_zero     (padding_zero),
        .addr             (addr),
        .store_data       (store_data),
        .stall            (stall),
        .load_data        (load_data),
        .load_valid       (load_valid),
        .bus_err          (bus_err),
`ifdef DMEM_MISALIGN_TRAP_EN
        .misalign_err     (misalign_err),
`endif
        .dm               (dm_bus)
    );

    typedef struct {
        logic        stall;
        logic        valid;
        logic        write;
        logic        lv;
        logic        be;
        logic        me;
        logic        chk_wd;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] ld;
    } exp_t;

    exp_t        expq[$];
    exp_t        ce;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          stall_seen = 0;
    logic [31:0] last_ld = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    // Lane model: sz 0=byte 1=half 2=word.
    function automatic logic [3:0] m_wstrb(input int sz, input logic [1:0] a);
        int s;
        if (sz == 0) s = 1 << int'(a);
        else if (sz == 1) s = 3 << (int'(a) & 2);
        else s = 15;
        return s[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] sd);
        if (sz == 0) return {24'h0, sd[7:0]} * 32'h0101_0101;
        if (sz == 1) return {16'h0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input int sz, input logic [1:0] a,
                                           input logic [31:0] rd, input bit z);
        logic [31:0] v;
        if (sz == 0) begin
            v = (rd >> (8 * int'(a))) & 32'hFF;
            if (!z && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (rd >> (16 * (int'(a) / 2))) & 32'hFFFF;
            if (!z && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic bit m_mis(input int sz, input logic [1:0] a);
        return (sz == 1 && a[0]) || (sz == 2 && a != 2'b00);
    endfunction

    function automatic exp_t mk(input logic st);
        exp_t e;
        e.stall = st;  e.valid = 1'b0; e.write = 1'b0; e.lv = 1'b0; e.be = 1'b0;
        e.me = 1'b0;   e.chk_wd = 1'b0; e.addr = '0; e.wstrb = '0; e.wdata = '0;
        e.ld = last_ld;
        return e;
    endfunction

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            ce = expq.pop_front();
            chk("stall", stall, ce.stall);
            chk("req_valid", dm_bus.dm_req_valid, ce.valid);
            chk("load_valid", load_valid, ce.lv);
            chk("bus_err", bus_err, ce.be);
            chk("load_data", load_data, ce.ld);
`ifdef DMEM_MISALIGN_TRAP_EN
            chk("misalign_err", misalign_err, ce.me);
`endif
            if (ce.valid) begin
                chk("req_write", dm_bus.dm_req_write, ce.write);
                chk("req_addr", dm_bus.dm_req_addr, ce.addr);
                chk("req_wstrb", dm_bus.dm_req_wstrb, ce.wstrb);
                if (ce.chk_wd) chk("req_wdata", dm_bus.dm_req_wdata, ce.wdata);
            end
            if (stall) stall_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs captured at request time are scrambled afterwards to prove they were registered.
    task automatic scramble();
        addr             = $urandom;
        store_data       = $urandom;
        padding_zero     = 1'($urandom % 2);
        memin_low_byte   = 1'($urandom % 2);
        memin_half_word  = 1'($urandom % 2);
        memout_low_byte  = 1'($urandom % 2);
        memout_half_word = 1'($urandom % 2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            read_mem = 1'b0;
            write_mem = 1'b0;
            dm_bus.dm_req_ready  = 1'($urandom % 2);
            dm_bus.dm_resp_valid = 1'($urandom % 2);
            dm_bus.dm_resp_rdata = $urandom;
            expq.push_back(mk(1'b0));
        end
    endtask

    // r: REQ cycles with ready low; d: RESP cycles before response (d >= TO means none).
    task automatic access(input bit rd, input int sz, input bit z, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rdat,
                          input int r, input int d);
        exp_t e;
        exp_t er;
        bit   to;
        bit   trap;
        int   n;
`ifdef DMEM_MISALIGN_TRAP_EN
        trap = m_mis(sz, a[1:0]);
`else
        trap = 1'b0;
`endif
        to = (d >= int'(TO));
        n  = to ? int'(TO) : d + 1;

        tick();
        read_mem         = rd;
        write_mem        = !rd;
        memout_low_byte  = rd && sz == 0;
        memout_half_word = rd && sz == 1;
        memin_low_byte   = !rd && sz == 0;
        memin_half_word  = !rd && sz == 1;
        padding_zero     = z;
        addr             = a;
        store_data       = sd;
        dm_bus.dm_req_ready  = 1'b0;
        dm_bus.dm_resp_valid = 1'($urandom % 2);
        dm_bus.dm_resp_rdata = $urandom;
        expq.push_back(mk(1'b1));

        if (trap) begin
            tick();
            scramble();
            dm_bus.dm_resp_valid = 1'b0;
            last_ld = '0;
            e = mk(1'b0);
            e.me = 1'b1;
            expq.push_back(e);
            return;
        end

        er        = mk(1'b1);
        er.valid  = 1'b1;
        er.write  = !rd;
        er.addr   = {a[31:2], 2'b00};
        er.wstrb  = rd ? 4'h0 : m_wstrb(sz, a[1:0]);
        er.wdata  = m_wdata(sz, sd);
        er.chk_wd = !rd;
        for (int k = 0; k <= r; k++) begin
            tick();
            scramble();
            dm_bus.dm_req_ready  = (k == r);
            dm_bus.dm_resp_valid = 1'($urandom % 2);
            dm_bus.dm_resp_rdata = $urandom;
            expq.push_back(er);
        end
        for (int j = 0; j < n; j++) begin
            tick();
            scramble();
            dm_bus.dm_req_ready  = 1'($urandom % 2);
            dm_bus.dm_resp_valid = !to && j == d;
            dm_bus.dm_resp_rdata = (!to && j == d) ? rdat : $urandom;
            expq.push_back(mk(1'b1));
        end
        tick();
        scramble();
        dm_bus.dm_req_ready  = 1'($urandom % 2);
        dm_bus.dm_resp_valid = 1'($urandom % 2);
        dm_bus.dm_resp_rdata = $urandom;
        if (to) last_ld = '0;
        else if (rd) last_ld = m_load(sz, a[1:0], rdat, z);
        e = mk(1'b0);
        e.lv = rd && !to;
        e.be = to;
        expq.push_back(e);
    endtask

    initial begin
        dm_bus.dm_req_ready  = 1'b0;
        dm_bus.dm_resp_valid = 1'b0;
        dm_bus.dm_resp_rdata = '0;

        // Reset state.
        tick();
        expq.push_back(mk(1'b0));
        chk("rst_stall", stall, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_req_valid", dm_bus.dm_req_valid, 32'd0);
        chk("rst_req_addr", dm_bus.dm_req_addr, 32'd0);
        chk("rst_req_wstrb", dm_bus.dm_req_wstrb, 32'd0);
        tick();
        rst_n = 1'b1;
        expq.push_back(mk(1'b0));
        idle(2);

        // Pin the model against hand-computed values.
        chk("pin_sb_wstrb", m_wstrb(0, 2'd2), 32'h4);
        chk("pin_sb_wdata", m_wdata(0, 32'hAABB_CCDD), 32'hDDDD_DDDD);
        chk("pin_sh_wstrb", m_wstrb(1, 2'd3), 32'hC);
        chk("pin_lb_sext", m_load(0, 2'd3, 32'h80FF_1234, 1'b0), 32'hFFFF_FF80);
        chk("pin_lb_zext", m_load(0, 2'd3, 32'h80FF_1234, 1'b1), 32'h0000_0080);
        chk("pin_lh_sext", m_load(1, 2'd2, 32'h8001_7FFF, 1'b0), 32'hFFFF_8001);

        // SB, immediate ready and response.
        stall_seen = 0;
        access(1'b0, 0, 1'b0, 32'h0000_1002, 32'hAABB_CCDD, 32'h0, 0, 0);
        chk("sb_stall_cycles", stall_seen, 32'd3);
        chk("sb_done_stall", stall, 32'd0);
        idle(1);

        access(1'b1, 0, 1'b0, 32'h0000_2003, 32'h0, 32'h80FF_1234, 0, 0);
        chk("lb_load_data", load_data, 32'hFFFF_FF80);
        chk("lb_load_valid", load_valid, 32'd1);
        access(1'b1, 0, 1'b1, 32'h0000_2003, 32'h0, 32'h80FF_1234, 0, 0);
        chk("lbu_load_data", load_data, 32'h0000_0080);
        idle(1);

        access(1'b1, 1, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 5, 1);
        chk("lh_load_data", load_data, 32'hFFFF_8001);
        idle(1);

        // No response: timeout after TO cycles in RESP.
        stall_seen = 0;
        access(1'b1, 2, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 0, 100);
        chk("to_bus_err", bus_err, 32'd1);
        chk("to_load_data", load_data, 32'd0);
        chk("to_load_valid", load_valid, 32'd0);
        chk("to_stall_cycles", stall_seen, 32'd6);
        idle(1);

`ifdef DMEM_MISALIGN_TRAP_EN
        stall_seen = 0;
        access(1'b1, 2, 1'b0, 32'h0000_3001, 32'h0, 32'h1234_5678, 0, 0);
        chk("mis_err", misalign_err, 32'd1);
        chk("mis_stall_cycles", stall_seen, 32'd1);
        idle(1);
`endif

        for (int t = 0; t < 300; t++) begin
            access(1'($urandom % 2), int'($urandom % 3), 1'($urandom % 2), $urandom,
                   $urandom, $urandom, int'($urandom % 4), int'($urandom % 6));
            idle(int'($urandom % 3));
        end

        // Reset in RESP, then a stale response arrives in IDLE.
        idle(1);
        tick();
        read_mem = 1'b1; write_mem = 1'b0; memout_low_byte = 1'b1; memout_half_word = 1'b0;
        padding_zero = 1'b0; addr = 32'h0000_2003;
        dm_bus.dm_req_ready = 1'b0; dm_bus.dm_resp_valid = 1'b0;
        expq.push_back(mk(1'b1));
        tick();
        dm_bus.dm_req_ready = 1'b1;
        ce = mk(1'b1);
        ce.valid = 1'b1; ce.addr = 32'h0000_2000;
        expq.push_back(ce);
        tick();
        dm_bus.dm_req_ready = 1'b0;
        expq.push_back(mk(1'b1));
        tick();
        rst_n = 1'b0;
        read_mem = 1'b0; memout_low_byte = 1'b0;
        last_ld = '0;
        expq.push_back(mk(1'b0));
        #1;
        chk("rst_mid_req_addr", dm_bus.dm_req_addr, 32'd0);
        chk("rst_mid_stall", stall, 32'd0);
        tick();
        expq.push_back(mk(1'b0));
        tick();
        rst_n = 1'b1;
        dm_bus.dm_resp_valid = 1'b1;
        dm_bus.dm_resp_rdata = 32'h80FF_1234;
        expq.push_back(mk(1'b0));
        tick();
        dm_bus.dm_resp_valid = 1'b0;
        expq.push_back(mk(1'b0));
        chk("stale_load_valid", load_valid, 32'd0);
        chk("stale_load_data", load_data, 32'd0);
        chk("stale_stall", stall, 32'd0);
        idle(2);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every CPU load/store onto the data-memory request/response bus and stalls the pipeline until the access completes.
- Sits between the MEM stage (fed by the decoder's read_mem/write_mem, byte/half-word and padding_zero controls) and the data-memory wrapper.
- Generates byte strobes and lane-replicated store data; extracts, sign-extends or zero-extends load data.
- Bounds bus wait time with a response timeout.

Parameters:
RESP_TIMEOUT, 255, cycles waited in RESP before abort; 0 disables the timeout.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
read_mem  in  1  MEM-stage load request
write_mem  in  1  MEM-stage store request
memin_low_byte  in  1  store byte (SB)
memin_half_word  in  1  store half (SH)
memout_low_byte  in  1  load byte
memout_half_word  in  1  load half
padding_zero  in  1  zero-extend load (LBU/LHU)
addr  in  32  byte address from ALU
store_data  in  32  rs2 value
stall  out  1  freeze IF..MEM, combinational
load_data  out  32  extended load result, registered
load_valid  out  1  one-cycle pulse, load_data valid
bus_err  out  1  one-cycle pulse, timeout abort
dm_req_valid  out  1  request valid
dm_req_ready  in  1  wrapper accepts request
dm_req_write  out  1  1 = store
dm_req_addr  out  32  {addr[31:2],2'b00}
dm_req_wstrb  out  4  byte enables, 0 for reads
dm_req_wdata  out  32  lane-replicated store data
dm_resp_valid  in  1  response valid (reads and writes)
dm_resp_rdata  in  32  read word

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0; captured request registers 0.
- Reset may assert in any state. It abandons the access. Any later dm_resp_valid arrives while in IDLE and is ignored.
- States: IDLE, REQ, RESP, DONE.
- IDLE, read_mem|write_mem=1:
  - stall=1 combinationally in the same cycle.
  - Capture addr, size, extension mode and write data into registers.
  - Next state REQ.
  - If both read_mem and write_mem are set, read wins (decoder never does this).
- REQ:
  - dm_req_valid=1, and every dm_req_* field stays stable until dm_req_ready=1.
  - Ready → RESP.
  - stall=1.
- RESP:
  - stall=1; counter increments each cycle.
  - dm_resp_valid → DONE. For reads, load_data is loaded from dm_resp_rdata after lane extraction.
  - If RESP_TIMEOUT≠0 and counter reaches RESP_TIMEOUT-1 without a response → DONE with bus_err pulse and load_data=0.
  - Counter clears on leaving RESP.
- DONE:
  - stall=0, so the pipeline advances this cycle.
  - load_valid=1 only if the access was a read.
  - Next state IDLE unconditionally. The new MEM-stage instruction is sampled next cycle, so there is no re-trigger.
- Minimum access with ready and response each arriving in the first cycle: 4 cycles total, stall high for 3.
- dm_resp_valid outside RESP is ignored.
- Store lanes:
  - Byte: wstrb=4'b0001<<addr[1:0], wdata={4{store_data[7:0]}}.
  - Half: wstrb=4'b0011<<{addr[1],1'b0}, wdata={2{store_data[15:0]}}.
  - Word: wstrb=4'hF, wdata=store_data.
- Load lanes:
  - Byte: rdata byte addr[1:0].
  - Half: rdata half addr[1].
  - Word: full rdata.
  - Extension: sign-extend unless padding_zero=1, then zero-extend.
- Misalignment (half with addr[0]=1; word with addr[1:0]≠0) without the optional feature: low address bits select lanes as above, with no trap.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined: a misaligned access skips the bus and goes IDLE→DONE directly. Adds output misalign_err (1-bit pulse in DONE); load_data=0, load_valid=0; stall high for 1 cycle.
- Undefined: misalign_err port absent; misaligned accesses behave as the lane rules dictate.

Decomposition:
- Package dmem_pkg holds:
  - enum dmem_state_e {IDLE, REQ, RESP, DONE};
  - enum dmem_size_e {SZ_BYTE, SZ_HALF, SZ_WORD};
  - constants WSTRB_BYTE=4'b0001, WSTRB_HALF=4'b0011, WSTRB_WORD=4'hF.
- One sub-module, dmem_lane_align: combinational strobe/replication for stores and extraction/extension for loads. It is reused by the wrapper's model.

Test Plan:
- SB addr=0x1002, store_data=0xAABBCCDD, ready and response immediate → wstrb=4'b0100, wdata=0xDDDDDDDD, dm_req_addr=0x1000, stall high 3 cycles.
- LB addr=0x2003, rdata=0x80FF_1234 → load_data=0xFFFFFF80, load_valid pulse in DONE; repeat with padding_zero=1 → 0x00000080.
- LH addr=0x2002, rdata=0x8001_7FFF, ready held low 5 cycles → dm_req_* stable throughout; load_data=0xFFFF8001.
- RESP_TIMEOUT=4, no dm_resp_valid → bus_err pulse after 4 RESP cycles, load_data=0, return to IDLE.
- rst_n low while in RESP, then dm_resp_valid arrives after release → outputs 0, state IDLE, response ignored, no load_valid.
- With DMEM_MISALIGN_TRAP_EN, LW addr=0x3001 → no dm_req_valid, misalign_err pulse, stall high 1 cycle.
